// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the register-file read ports, the mult/div unit and write-back.
// The master drives operation requests; the slave returns busy/done and the HI/LO registers.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with architectural HI/LO registers and MTHI/MTLO writes while idle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// RUN   | ITERS iteration steps on magnitudes, counter counts down to 0
// FIN   | sign correction, hi/lo written, done pulsed
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  mips_muldiv_if.slave bus
);

  localparam int CW = $clog2(ITERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // operand magnitudes at request time
  logic               signed_op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sa        = signed_op & bus.a[WIDTH-1];
    sb        = signed_op & bus.b[WIDTH-1];
    amag      = sa ? (-bus.a) : bus.a;
    bmag      = sb ? (-bus.b) : bus.b;
  end

  // p holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   step_p;

  always_comb begin
    add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ma} : {(WIDTH+1){1'b0}});
    shifted = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mb};
    if (is_div) begin
      if (diff[WIDTH+1])
        step_p = {shifted[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else
        step_p = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end else begin
      step_p = {add_sum, p[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    prod   = neg_q ? (-p) : p;
    quo    = neg_q ? (-p[WIDTH-1:0]) : p[WIDTH-1:0];
    rem    = neg_r ? (-p[2*WIDTH-1:WIDTH]) : p[2*WIDTH-1:WIDTH];
    a_orig = neg_r ? (-ma) : ma;
    if (!is_div) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (mb == '0) begin
      // divide by zero returns all-ones quotient and the untouched dividend
      fin_hi = a_orig;
      fin_lo = '1;
    end else begin
      fin_hi = rem;
      fin_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p      <= '0;
      ma     <= '0;
      mb     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                ma     <= amag;
                mb     <= bmag;
                is_div <= bus.op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                p      <= bus.op[1] ? {{WIDTH{1'b0}}, amag} : {{WIDTH{1'b0}}, bmag};
                cnt    <= CW'(ITERS - 1);
                busy_q <= 1'b1;
                state  <= S_RUN;
              end
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          p   <= step_p;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_FIN;
        end
        S_FIN: begin
          hi_q   <= fin_hi;
          lo_q   <= fin_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: arithmetic results, timing, special divides,
// MTHI/MTLO behaviour, back-to-back issue and reset abort.
module tb_mips_muldiv;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32), .ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one-edge start pulse; returns 1 time unit after the accepting edge
  task automatic pulse_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // issue an op and wait (bounded) for done; lat = edges from start edge to done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output int lat);
    pulse_start(op, a, b);
    busy_cycles = bus.busy ? 1 : 0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    total++; if (bus.hi !== 32'h0)   begin bad++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0)   begin bad++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
    total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_multu_max();
    int bc, lat;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, lat);
    total++; if (lat !== 33)          begin bad++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    total++; if (bc !== 33)           begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL multu_busy_at_done got=%b exp=0", bus.busy); end
    total++; if (bus.hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h exp=%h", bus.hi, 32'hFFFFFFFE); end
    total++; if (bus.lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h exp=%h", bus.lo, 32'h1); end
    @(posedge clk);
    #1;
    total++; if (bus.done !== 1'b0)   begin bad++; $display("FAIL multu_done_one_cycle got=%b exp=0", bus.done); end
  endtask

  task automatic test_signed();
    int bc, lat;
    run_op(OP_MULT, 32'hFFFFFFF9, 32'd6, bc, lat);
    total++; if (lat !== 33)              begin bad++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=%h", bus.hi, 32'hFFFFFFFF); end
    total++; if (bus.lo !== 32'hFFFFFFD6) begin bad++; $display("FAIL mult_lo got=%h exp=%h", bus.lo, 32'hFFFFFFD6); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, bc, lat);
    total++; if (lat !== 33)              begin bad++; $display("FAIL div_latency got=%0d exp=33", lat); end
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_quo got=%h exp=%h", bus.lo, 32'hFFFFFFFD); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_rem got=%h exp=%h", bus.hi, 32'hFFFFFFFF); end
  endtask

  task automatic test_div_special();
    int bc, lat;
    run_op(OP_DIVU, 32'd100, 32'd0, bc, lat);
    total++; if (lat !== 33)              begin bad++; $display("FAIL divz_latency got=%0d exp=33", lat); end
    total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_lo got=%h exp=%h", bus.lo, 32'hFFFFFFFF); end
    total++; if (bus.hi !== 32'd100)      begin bad++; $display("FAIL divz_hi got=%h exp=%h", bus.hi, 32'd100); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, lat);
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h exp=%h", bus.lo, 32'h80000000); end
    total++; if (bus.hi !== 32'h0)        begin bad++; $display("FAIL divovf_hi got=%h exp=%h", bus.hi, 32'h0); end
  endtask

  task automatic test_mthi_idle();
    pulse_start(OP_MTHI, 32'h1234, 32'h0);
    total++; if (bus.hi !== 32'h1234)     begin bad++; $display("FAIL mthi_hi got=%h exp=%h", bus.hi, 32'h1234); end
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL mthi_lo_kept got=%h exp=%h", bus.lo, 32'h80000000); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0)       begin bad++; $display("FAIL mthi_done got=%b exp=0", bus.done); end
    @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL mthi_after busy=%b done=%b exp=0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_ignored_while_busy();
    int lat;
    pulse_start(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    pulse_start(OP_MTHI, 32'h0000BEEF, 32'h0);
    pulse_start(OP_MTLO, 32'h0000CAFE, 32'h0);
    total++; if (bus.hi !== 32'h1234)     begin bad++; $display("FAIL busy_hi_hold got=%h exp=%h", bus.hi, 32'h1234); end
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL busy_lo_hold got=%h exp=%h", bus.lo, 32'h80000000); end
    lat = 6;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    total++; if (lat !== 33)      begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (bus.hi !== 32'd2)  begin bad++; $display("FAIL divu_rem got=%h exp=%h", bus.hi, 32'd2); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_quo got=%h exp=%h", bus.lo, 32'd14); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    pulse_start(OP_MULTU, 32'd3, 32'd5);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      if (lat == 9) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd7; bus.b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    total++; if (lat !== 33)       begin bad++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
    total++; if (bus.lo !== 32'd15) begin bad++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.lo, 32'd15); end
    total++; if (bus.hi !== 32'd0)  begin bad++; $display("FAIL b2b_first_hi got=%h exp=%h", bus.hi, 32'd0); end
    pulse_start(OP_MULTU, 32'h00010000, 32'h00010000);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b exp=1", bus.busy); end
    lat2 = 1;
    while (lat2 < 60) begin
      @(posedge clk);
      #1;
      lat2++;
      if (bus.done) break;
    end
    total++; if (lat2 !== 34)      begin bad++; $display("FAIL b2b_done_to_done got=%0d exp=34", lat2); end
    total++; if (bus.hi !== 32'd1)  begin bad++; $display("FAIL b2b_second_hi got=%h exp=%h", bus.hi, 32'd1); end
    total++; if (bus.lo !== 32'd0)  begin bad++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.lo, 32'd0); end
  endtask

  task automatic test_reset_abort();
    int seen_done;
    pulse_start(OP_MTHI, 32'd5, 32'd0);
    pulse_start(OP_MTLO, 32'd6, 32'd0);
    total++; if (bus.hi !== 32'd5 || bus.lo !== 32'd6) begin
      bad++; $display("FAIL abort_preload hi=%h lo=%h exp=5/6", bus.hi, bus.lo);
    end
    pulse_start(OP_MULT, 32'd3, 32'd4);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.hi !== 32'd0)  begin bad++; $display("FAIL abort_hi got=%h exp=0", bus.hi); end
    total++; if (bus.lo !== 32'd0)  begin bad++; $display("FAIL abort_lo got=%h exp=0", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    total++; if (seen_done !== 0)   begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++; $display("FAIL abort_hold hi=%h lo=%h exp=0/0", bus.hi, bus.lo);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_multu_max();
    test_signed();
    test_div_special();
    test_mthi_idle();
    test_ignored_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
